// File: rtl/dec_scan_pkg.sv
// Shared definitions for the scanning one-hot decoder: mode encodings and
// parameter helpers used by dec_scan and dec_onehot.
package dec_scan_pkg;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic bit dec_params_ok(input int n, input int dwell);
        return (n >= 1) && (dwell >= 1);
    endfunction

    // A DWELL of 1 still needs a one-bit counter so the compare stays well formed.
    function automatic int dwell_cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2^N one-hot decoder, MSB-first: code k drives y[2^N-1-k].
module dec_onehot
    import dec_scan_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]        sel,
    output logic [(1<<N)-1:0]   y
);

    localparam int W = 1 << N;

    always_comb begin
        y = '0;
        for (int k = 0; k < W; k++) begin
            y[W-1-k] = (sel == N'(k));
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with an auto-scan mode that steps through all
// codes from a loaded start value, holding each for DWELL enabled cycles.
module dec_scan
    import dec_scan_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                load,
    input  logic [N-1:0]        data_in,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        code,
    output logic                wrap
);

    localparam int W  = 1 << N;
    localparam int CW = dwell_cnt_width(DWELL);

    if (!dec_params_ok(N, DWELL)) begin : g_param_check
        $error("dec_scan: illegal parameters N=%0d DWELL=%0d", N, DWELL);
    end

    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [N-1:0]   code_nxt;
    logic           wrap_nxt;
    logic [W-1:0]   dec_y;
    logic [W-1:0]   y_nxt;

    dec_onehot #(.N(N)) u_onehot (
        .sel (code_nxt),
        .y   (dec_y)
    );

    // Load always wins over dwell expiry; every path except a counting SCAN
    // cycle returns the counter to zero.
    always_comb begin
        code_nxt = code;
        cnt_nxt  = '0;
        wrap_nxt = 1'b0;
        if (!en) begin
            if (load) code_nxt = data_in;
        end else if (mode == MODE_DECODE) begin
            code_nxt = data_in;
        end else if (load) begin
            code_nxt = data_in;
        end else if (cnt == CW'(DWELL - 1)) begin
            code_nxt = code + N'(1);
            wrap_nxt = (code == {N{1'b1}});
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
        y_nxt = en ? dec_y : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
            y    <= '0;
        end else begin
            code <= code_nxt;
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
            y    <= y_nxt;
        end
    end

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised, registered N-to-2^N one-hot decoder with an auto-scan mode. In decode mode it registers the one-hot decode of `data_in` every cycle. In scan mode it steps through all codes from a loaded start value, holding each code for a programmable dwell time. It drives row/digit-select lines, LED walkers and strobe generators wherever the fixed 3-to-8 decoders fall short.

## Interface
Parameters:
- `N`, 3, select width; output width is 2^N; legal range N ≥ 1.
- `DWELL`, 4, cycles each code is held in scan mode; legal range DWELL ≥ 1.

Ports:
- `clk`  in  1  — system clock.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `en`  in  1  — enable. When 0, `y` is forced to 0 and the dwell counter is cleared.
- `mode`  in  1  — 0 = DECODE, 1 = SCAN.
- `load`  in  1  — latch `data_in` as the scan start code; honoured regardless of `en` or `mode`.
- `data_in`  in  N  — code to decode, or scan start code.
- `y`  out  2^N  — registered one-hot output, MSB-first: code k asserts `y[2^N-1-k]`.
- `code`  out  N  — current code register.
- `wrap`  out  1  — one-cycle pulse when a scan step wraps from 2^N-1 to 0.

## Operation
- Mode selection is decoded each cycle from sampled `en`/`mode`:
  - OFF: `en`=0.
  - DECODE: `en`=1, `mode`=0.
  - SCAN: `en`=1, `mode`=1.
  - No other state is held; `code` and the dwell counter carry all history.
- OFF:
  - `y` <= 0; dwell counter <= 0; `wrap` <= 0.
  - `code` holds, except that `load` sets `code` <= `data_in`.
- DECODE:
  - `code` <= `data_in` every cycle; `load` is redundant.
  - Dwell counter <= 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1: `code` <= (`code`+1) mod 2^N and counter <= 0.
  - If the old `code` was 2^N-1, `wrap` <= 1 for that cycle.
- Output decode: `y` <= `en` ? onehot(next `code`) : 0, so `y` and `code` always update on the same edge. In any enabled cycle exactly one bit of `y` is set.
- Arithmetic: code increment is N-bit unsigned and wraps naturally. Dwell counter width is max(1, clog2(DWELL)).
- Boundary conditions:
  - `load` and dwell expiry in the same cycle: load wins, counter <= 0, no `wrap`.
  - `load` during SCAN: new code appears on `y` next edge and gets a full DWELL cycles.
  - DECODE→SCAN: scan starts from the current `code` with counter 0, so the first code is held a full DWELL.
  - SCAN→DECODE: `code` follows `data_in` immediately.
  - DWELL=1: advance every enabled SCAN cycle.
  - N=1: `y` is 2 bits; scan alternates `10`/`01`, and `wrap` fires every second step.
  - `en` dropping mid-dwell: counter clears. On re-enable the current code is held a full DWELL again.

## Timing
- Reset values: `y`=0, `code`=0, `wrap`=0, dwell counter=0. Reset is asynchronous assert; release is synchronous to `clk` (synchroniser lives upstream).
- DECODE latency: `data_in` sampled at edge k appears on `y`/`code` after edge k (1 cycle).
- `load` latency: 1 cycle.
- `en`→`y`=0: 1 cycle.
- SCAN: each code is visible on `y` for exactly DWELL cycles while `en` stays high.
- `wrap` is high for exactly one cycle: the cycle in which `code`=0 first appears after 2^N-1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package/header holds:
  - `MODE_DECODE`=1'b0 and `MODE_SCAN`=1'b1.
  - Decoder parameter checks (N ≥ 1, DWELL ≥ 1), enforced by elaboration-time assertions.
- Sub-module `dec_onehot` is a purely combinational parametrised N-to-2^N MSB-first one-hot decoder with no enable. `dec_scan` instantiates it on the next-code value and registers the result.
- All sequential logic (code register, dwell counter, `wrap`, `y` register) lives in `dec_scan`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `y`=0, `code`=0, `wrap`=0. Assert `rst_n` low mid-SCAN, asynchronously between edges → outputs go to 0 immediately.
- DECODE, N=3: `en`=1, `mode`=0, `data_in`=5 → next edge `y`=8'b00000100, `code`=5. `data_in`=0 → `y`=8'b10000000. Drop `en` → `y`=0 one edge later.
- SCAN, N=3, DWELL=4: `load` with `data_in`=6, then `mode`=1 → `y`=00000010 for 4 cycles, then 00000001 for 4, then 10000000 with `wrap`=1 on its first cycle only.
- Collision: `load` with `data_in`=2 on the exact cycle the dwell expires from code 7 → `code`=2, `y`=00100000, `wrap`=0, and code 2 is held for 4 full cycles.
- Enable gap: drop `en` for 2 cycles in the middle of a dwell, then re-enable → `y`=0 during the gap, the same code resumes, and it is held a full DWELL.
- N=4, DWELL=1: `load` 0, then scan → `y` walks bit 15 down to bit 0 in 16 consecutive cycles, then `wrap`=1 as `y` returns to bit 15.
